// File: rtl/pipe_drain_pkg.sv
// Shared defaults, width helpers and beat type for the pipeline drain FIFO.
package pipe_drain_pkg;

  localparam int DEF_WIDTH = 100;
  localparam int DEF_DEPTH = 4;

  typedef logic [DEF_WIDTH-1:0] beat_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_drain_mem.sv
// DEPTH x WIDTH storage array: synchronous write, asynchronous read, no reset.
module pipe_drain_mem
  import pipe_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/pipe_drain_fifo.sv
// First-word-fall-through drain buffer between the last pipeline stage and a
// valid/ready consumer. Optional popped-beat counter: PIPE_DRAIN_FIFO_CNT_EN.
module pipe_drain_fifo
  import pipe_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inValid,
  input  logic [WIDTH-1:0]          inData,
  output logic                      inAllow,
  output logic                      outValid,
  output logic [WIDTH-1:0]          outData,
  input  logic                      outReady,
  output logic [lvl_w(DEPTH)-1:0]   level
`ifdef PIPE_DRAIN_FIFO_CNT_EN
  ,
  output logic [CNT_W-1:0]          xferCnt
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : gBadParam
    $error("pipe_drain_fifo: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [LW-1:0] count;
  logic          push;
  logic          pop;

  // Full blocks the producer even when the consumer pops, so inAllow
  // never depends combinationally on outReady.
  assign inAllow  = (count != FULL_LVL);
  assign outValid = (count != '0);
  assign level    = count;
  assign push     = inValid && inAllow;
  assign pop      = outValid && outReady;

  pipe_drain_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) uMem (
    .clk    (clk),
    .wrEn   (push),
    .wrAddr (wrPtr),
    .wrData (inData),
    .rdAddr (rdPtr),
    .rdData (outData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PIPE_DRAIN_FIFO_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xferCnt <= '0;
    end else if (pop) begin
      xferCnt <= xferCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Scoreboard bench for pipe_drain_fifo: directed fill/drain/stream, random
// stall traffic, asynchronous mid-operation reset and the optional counter.
module tb_pipe_drain_fifo;

  localparam int WIDTH = 100;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inValid = 1'b0;
  logic [WIDTH-1:0] inData = '0;
  logic             inAllow;
  logic             outValid;
  logic [WIDTH-1:0] outData;
  logic             outReady = 1'b0;
  logic [2:0]       level;
`ifdef PIPE_DRAIN_FIFO_CNT_EN
  logic [CNT_W-1:0] xferCnt;
`endif

  int total = 0;
  int bad = 0;
  int mCount = 0;
  logic [CNT_W-1:0] mXfer = '0;
  logic [WIDTH-1:0] sb [$];
  bit monEn = 1'b0;
  int accepted = 0;
  int budget = 0;

  pipe_drain_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inData   (inData),
    .inAllow  (inAllow),
    .outValid (outValid),
    .outData  (outData),
    .outReady (outReady),
    .level    (level)
`ifdef PIPE_DRAIN_FIFO_CNT_EN
    ,
    .xferCnt  (xferCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    @(posedge clk);
    #1;
    inValid  = v;
    inData   = d;
    outReady = r;
  endtask

  // Reference model: expected beats enter the queue when the stimulus is accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCount <= 0;
      mXfer  <= '0;
      sb.delete();
    end else begin
      if (mCount != 0 && outReady) begin
        void'(sb.pop_front());
        mXfer <= mXfer + 1'b1;
      end
      if (inValid && mCount != DEPTH) sb.push_back(inData);
      mCount <= mCount + int'(inValid && mCount != DEPTH) - int'(mCount != 0 && outReady);
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (monEn && rst_n) begin
      checkOutput("inAllow", 128'(inAllow), 128'(mCount != DEPTH));
      checkOutput("outValid", 128'(outValid), 128'(mCount != 0));
      checkOutput("level", 128'(level), 128'(mCount));
      if (mCount != 0 && outReady) checkOutput("outData", 128'(outData), 128'(sb[0]));
`ifdef PIPE_DRAIN_FIFO_CNT_EN
      checkOutput("xferCnt", 128'(xferCnt), 128'(mXfer));
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] rnd;

    // Reset state, during and after reset
    #12;
    checkOutput("rst_inAllow", 128'(inAllow), 128'(1));
    checkOutput("rst_outValid", 128'(outValid), 128'(0));
    checkOutput("rst_level", 128'(level), 128'(0));
    #5 rst_n = 1'b1;
    monEn = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("post_rst_level", 128'(level), 128'(0));

    // Fill to full, then offer 0xA5 which must be held off
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, WIDTH'(8'hA1 + i), 1'b0);
    applyStimulus(1'b1, WIDTH'(8'hA5), 1'b0);
    checkOutput("full_inAllow", 128'(inAllow), 128'(0));
    checkOutput("full_level", 128'(level), 128'(4));
    applyStimulus(1'b1, WIDTH'(8'hA5), 1'b0);
    applyStimulus(1'b1, WIDTH'(8'hA5), 1'b0);
    checkOutput("full_head", 128'(outData), 128'(8'hA1));

    // Drain; one pop reopens the input and 0xA5 goes in
    applyStimulus(1'b1, WIDTH'(8'hA5), 1'b1);
    @(posedge clk);
    #1;
    checkOutput("reopen_inAllow", 128'(inAllow), 128'(1));
    checkOutput("reopen_head", 128'(outData), 128'(8'hA2));
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("drained_level", 128'(level), 128'(0));

    // Streaming: push and pop every cycle
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, WIDTH'(32'h1000 + i), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);

    // Random data with random stalls until 1000 beats accepted
    accepted = 0;
    budget = 0;
    while (accepted < 1000 && budget < 20000) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 3) != 0), rnd[WIDTH-1:0], 1'($urandom_range(0, 2) != 0));
      if (inValid && mCount != DEPTH) accepted++;
      budget++;
    end
    if (accepted < 1000) checkOutput("random_budget", 128'(accepted), 128'(1000));
    budget = 0;
    applyStimulus(1'b0, '0, 1'b1);
    while (mCount != 0 && budget < 100) begin
      applyStimulus(1'b0, '0, 1'b1);
      budget++;
    end
    if (mCount != 0) checkOutput("drain_budget", 128'(mCount), 128'(0));

    // Asynchronous reset with three beats stored
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'(8'hC0 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pre_rst_level", 128'(level), 128'(3));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_outValid", 128'(outValid), 128'(0));
    checkOutput("async_level", 128'(level), 128'(0));
    checkOutput("async_inAllow", 128'(inAllow), 128'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Counter: 17 pops wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, WIDTH'(8'hE0 + i), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("cnt_level", 128'(level), 128'(0));
`ifdef PIPE_DRAIN_FIFO_CNT_EN
    checkOutput("xferCnt_wrap", 128'(xferCnt), 128'(1));
`endif

    monEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
